led_arbiter: RTL and testbench

LED_ARBITER -- requirements
Module: led_arbiter

---
 rtl/led_arbiter_pkg.sv | 12 +
 rtl/led_arbiter_pwm.sv | 34 +++
 rtl/led_arbiter.sv | 143 ++++++++++++++
 tb/tb_led_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_arbiter_pkg.sv
// Shared types and limits for the LED display arbiter.
package led_arbiter_pkg;

    localparam int unsigned MAX_REQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWNED   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/led_arbiter_pwm.sv
// Free-running dimming counter; pwm_o is high for the first PWM_DUTY cycles of each period.
module led_pwm
    import led_arbiter_pkg::*;
#(
    parameter int unsigned PWM_PERIOD = 5,
    parameter int unsigned PWM_DUTY   = 3
) (
    input  logic clk,
    input  logic reset,
    output logic pwm_o
);

    localparam int unsigned CW = $clog2(PWM_PERIOD);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(PWM_PERIOD - 1)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pwm_o = (32'(cnt_q) < PWM_DUTY);

endmodule

// File: rtl/led_arbiter.sv
// Round-robin arbiter granting the LED bank to one requester for a minimum hold time.
// Optional dimming is compiled in with the LED_ARBITER_PWM_EN macro.
module led_arbiter
    import led_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned HOLD_CYCLES = 1000,
    parameter int unsigned PWM_PERIOD  = 5,
    parameter int unsigned PWM_DUTY    = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [8*NUM_REQ-1:0]   data_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [2:0]             owner_o,
    output logic                   busy_o,
    output logic [7:0]             led_o
);

    localparam int unsigned HW   = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned IDXW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("led_arbiter: NUM_REQ out of range");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("led_arbiter: HOLD_CYCLES must be at least 1");
    end
    if (PWM_PERIOD < 2 || PWM_DUTY < 1 || PWM_DUTY > PWM_PERIOD) begin : g_bad_pwm
        $error("led_arbiter: PWM_PERIOD/PWM_DUTY out of range");
    end

    arb_state_e          state_q, state_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [2:0]          owner_q, owner_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [7:0]          led_q, led_d;

    logic [IDXW-1:0]     owner_idx;
    logic [IDXW-1:0]     idx;
    logic [2:0]          pick;
    logic                pick_vld;
    logic                others;
    logic [7:0]          owner_data;
    logic [7:0]          pwm_mask;

`ifdef LED_ARBITER_PWM_EN
    logic pwm;

    led_pwm #(
        .PWM_PERIOD (PWM_PERIOD),
        .PWM_DUTY   (PWM_DUTY)
    ) u_pwm (
        .clk   (clk),
        .reset (reset),
        .pwm_o (pwm)
    );

    assign pwm_mask = {8{pwm}};
`else
    assign pwm_mask = '1;
`endif

    assign owner_idx  = owner_q[IDXW-1:0];
    assign owner_data = data_i[{owner_idx, 3'b000} +: 8];
    assign others     = |(req_i & ~(NUM_REQ'(1) << owner_q));

    // Search starts just after the last owner, so the last owner is reached only last.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = IDXW'((32'(ptr_q) + i) % NUM_REQ);
            if (!pick_vld && req_i[idx]) begin
                pick     = 3'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        grant_d = '0;
        led_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_OWNED;
                    owner_d = pick;
                    hold_d  = HW'(HOLD_CYCLES - 1);
                    grant_d = NUM_REQ'(1) << pick;
                end
            end
            ST_OWNED: begin
                hold_d = (hold_q == '0) ? '0 : hold_q - 1'b1;
                // A drop and a preemption in the same cycle collapse into one release.
                if (!req_i[owner_idx] || (hold_q == '0 && others)) begin
                    state_d = ST_RELEASE;
                end else begin
                    grant_d = grant_q;
                    led_d   = owner_data & pwm_mask;
                end
            end
            ST_RELEASE: begin
                ptr_d   = owner_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 3'(NUM_REQ - 1);
            owner_q <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            led_q   <= led_d;
        end
    end

    assign grant_o = grant_q;
    assign owner_o = owner_q;
    assign busy_o  = (state_q == ST_OWNED);
    assign led_o   = led_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Self-checking bench for led_arbiter against a cycle-level ownership model.
module tb_led_arbiter;

    localparam int unsigned NR   = 4;
    localparam int unsigned HOLD = 4;
    localparam int unsigned PER  = 5;
    localparam int unsigned DUTY = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req;
    logic [8*NR-1:0] data;
    logic [NR-1:0]   grant_o;
    logic [2:0]      owner_o;
    logic            busy_o;
    logic [7:0]      led_o;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: who owns the LEDs, for how long, and whether a release gap is pending
    int         m_owner;
    bit         m_rel;
    int         m_last;
    int         m_elapsed;
    int         m_pcnt;
    logic [NR-1:0] exp_grant;
    logic          exp_busy;
    logic [2:0]    exp_owner;
    logic [7:0]    exp_led;

    led_arbiter #(
        .NUM_REQ     (NR),
        .HOLD_CYCLES (HOLD),
        .PWM_PERIOD  (PER),
        .PWM_DUTY    (DUTY)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req_i   (req),
        .data_i  (data),
        .grant_o (grant_o),
        .owner_o (owner_o),
        .busy_o  (busy_o),
        .led_o   (led_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_owner   = -1;
        m_rel     = 1'b0;
        m_last    = NR - 1;
        m_elapsed = 0;
        m_pcnt    = 0;
        exp_grant = '0;
        exp_busy  = 1'b0;
        exp_owner = '0;
        exp_led   = '0;
    endtask

    task automatic model_edge();
        bit pwm_on;
        logic [NR-1:0] mask;
`ifdef LED_ARBITER_PWM_EN
        pwm_on = (m_pcnt < DUTY);
`else
        pwm_on = 1'b1;
`endif
        m_pcnt  = (m_pcnt + 1) % PER;
        exp_led = '0;
        if (m_owner >= 0) begin
            mask = NR'(1) << m_owner;
            if (!req[m_owner] || (m_elapsed >= HOLD - 1 && (req & ~mask) != 0)) begin
                m_last  = m_owner;
                m_owner = -1;
                m_rel   = 1'b1;
            end else begin
                m_elapsed++;
                if (pwm_on) exp_led = data[8*m_owner +: 8];
            end
        end else if (m_rel) begin
            m_rel = 1'b0;
        end else if (req != '0) begin
            for (int k = 1; k <= NR; k++) begin
                if (m_owner < 0 && req[(m_last + k) % NR]) m_owner = (m_last + k) % NR;
            end
            m_elapsed = 0;
            exp_owner = 3'(m_owner);
        end
        exp_grant = (m_owner >= 0) ? NR'(1) << m_owner : '0;
        exp_busy  = (m_owner >= 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = '0;
        data  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        n_tests++;
        if (grant_o !== '0) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant_o); end
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_tests++;
        if (owner_o !== 3'd0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", owner_o); end
        n_tests++;
        if (led_o !== 8'h00) begin n_fail++; $display("FAIL reset_led: got %h want 00", led_o); end
    endtask

    task automatic test_first_grant();
        req  = 4'b0110;
        data = 32'hA1B2_C3D4;
        tick();
        n_tests++;
        if (grant_o !== 4'b0010 || owner_o !== 3'd1 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL first_grant: got grant=%b owner=%0d busy=%b want 0010/1/1", grant_o, owner_o, busy_o);
        end
        n_tests++;
        if (led_o !== 8'h00) begin n_fail++; $display("FAIL first_grant_led_latency: got %h want 00", led_o); end
        tick();
`ifndef LED_ARBITER_PWM_EN
        n_tests++;
        if (led_o !== 8'hC3) begin n_fail++; $display("FAIL first_grant_led: got %h want c3", led_o); end
`endif
        n_tests++;
        if (led_o !== exp_led) begin n_fail++; $display("FAIL first_grant_led_model: got %h want %h", led_o, exp_led); end
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_preempt();
        req  = 4'b0010;
        data = 32'h1122_3344;
        tick();
        n_tests++;
        if (grant_o !== 4'b0010) begin n_fail++; $display("FAIL preempt_owner1: got %b want 0010", grant_o); end
        req = 4'b0110;
        for (int c = 1; c <= 6; c++) begin
            tick();
            n_tests++;
            if (grant_o !== exp_grant || busy_o !== exp_busy || led_o !== exp_led) begin
                n_fail++;
                $display("FAIL preempt_model c%0d: got grant=%b busy=%b led=%h want %b/%b/%h",
                         c, grant_o, busy_o, led_o, exp_grant, exp_busy, exp_led);
            end
            if (c == 3) begin
                n_tests++;
                if (grant_o !== 4'b0010) begin n_fail++; $display("FAIL preempt_held: got %b want 0010", grant_o); end
            end
            if (c == 4 || c == 5) begin
                n_tests++;
                if (grant_o !== '0 || busy_o !== 1'b0 || led_o !== 8'h00) begin
                    n_fail++;
                    $display("FAIL preempt_gap c%0d: got grant=%b busy=%b led=%h want 0000/0/00", c, grant_o, busy_o, led_o);
                end
            end
            if (c == 6) begin
                n_tests++;
                if (grant_o !== 4'b0100 || owner_o !== 3'd2) begin
                    n_fail++;
                    $display("FAIL preempt_regrant: got grant=%b owner=%0d want 0100/2", grant_o, owner_o);
                end
            end
        end
    endtask

    task automatic test_drop();
        req = '0;
        repeat (2) tick();
        req  = 4'b0001;
        data = 32'h0000_005A;
        tick();
        n_tests++;
        if (grant_o !== 4'b0001) begin n_fail++; $display("FAIL drop_grant0: got %b want 0001", grant_o); end
        tick();
`ifndef LED_ARBITER_PWM_EN
        n_tests++;
        if (led_o !== 8'h5A) begin n_fail++; $display("FAIL drop_led_owned: got %h want 5a", led_o); end
`endif
        req = '0;
        tick();
        n_tests++;
        if (grant_o !== '0 || busy_o !== 1'b0 || led_o !== 8'h00) begin
            n_fail++;
            $display("FAIL drop_release: got grant=%b busy=%b led=%h want 0000/0/00", grant_o, busy_o, led_o);
        end
        tick();
    endtask

    task automatic test_single_hold();
        int bad = 0;
        req  = 4'b1000;
        data = 32'h7E00_0000;
        tick();
        for (int c = 0; c < 120; c++) begin
            if (c == 60) data = 32'h3C00_0000;
            tick();
            if (grant_o !== 4'b1000 || busy_o !== 1'b1) bad++;
            n_tests++;
            if (grant_o !== exp_grant || busy_o !== exp_busy || owner_o !== exp_owner || led_o !== exp_led) begin
                n_fail++;
                $display("FAIL single_hold_model c%0d: got grant=%b owner=%0d led=%h want %b/%0d/%h",
                         c, grant_o, owner_o, led_o, exp_grant, exp_owner, exp_led);
            end
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL single_hold_persist: got %0d lost cycles want 0", bad); end
    endtask

    task automatic test_async_reset();
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (grant_o !== '0 || busy_o !== 1'b0 || led_o !== 8'h00 || owner_o !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset: got grant=%b busy=%b led=%h owner=%0d want all zero", grant_o, busy_o, led_o, owner_o);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        req  = 4'b1001;
        data = 32'hEE00_0011;
        tick();
        n_tests++;
        if (grant_o !== 4'b0001 || owner_o !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset_regrant: got grant=%b owner=%0d want 0001/0", grant_o, owner_o);
        end
        req = '0;
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        req  = 4'b0100;
        data = 32'h0099_0000;
        tick();
        tick();
        req = '0;
        tick();
        req = 4'b0100;
        tick();
        n_tests++;
        if (grant_o !== '0) begin n_fail++; $display("FAIL b2b_idle_gap: got %b want 0000", grant_o); end
        tick();
        n_tests++;
        if (grant_o !== 4'b0100 || grant_o !== exp_grant) begin
            n_fail++;
            $display("FAIL b2b_regrant_same: got %b want 0100 (model %b)", grant_o, exp_grant);
        end
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = NR'($urandom_range(0, 15));
            data = $urandom;
            tick();
            n_tests++;
            if (grant_o !== exp_grant || busy_o !== exp_busy || led_o !== exp_led ||
                (exp_busy && owner_o !== exp_owner)) begin
                n_fail++;
                $display("FAIL random c%0d: got grant=%b busy=%b owner=%0d led=%h want %b/%b/%0d/%h",
                         c, grant_o, busy_o, owner_o, led_o, exp_grant, exp_busy, exp_owner, exp_led);
            end
        end
        req = '0;
        repeat (3) tick();
    endtask

`ifdef LED_ARBITER_PWM_EN
    task automatic test_pwm();
        logic [7:0] seen [10];
        int lit;
        req  = 4'b0001;
        data = 32'h0000_00FF;
        repeat (2) tick();
        for (int c = 0; c < 10; c++) begin
            tick();
            seen[c] = led_o;
            n_tests++;
            if (led_o !== exp_led) begin n_fail++; $display("FAIL pwm_model c%0d: got %h want %h", c, led_o, exp_led); end
        end
        lit = 0;
        for (int c = 0; c < 5; c++) begin
            if (seen[c] == 8'hFF) lit++;
            n_tests++;
            if (seen[c] !== seen[c+5] || (seen[c] !== 8'hFF && seen[c] !== 8'h00)) begin
                n_fail++;
                $display("FAIL pwm_repeat c%0d: got %h then %h want equal FF/00", c, seen[c], seen[c+5]);
            end
        end
        n_tests++;
        if (lit != DUTY) begin n_fail++; $display("FAIL pwm_duty: got %0d lit want %0d", lit, DUTY); end
        req = '0;
        repeat (3) tick();
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_first_grant();
        test_preempt();
        test_drop();
        test_single_hold();
        test_async_reset();
        test_back_to_back();
        test_random();
`ifdef LED_ARBITER_PWM_EN
        test_pwm();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
